// File: rtl/jtag_master.sv
// JTAG master: walks the target TAP through DR/IR scans or a TMS reset, shifting cmd_data out LSB first and capturing TDO.
// Latency: N+6 TCK (DR) / N+7 (IR) / 7 (TAP reset) from accept to cmd_ready; busy commands are ignored, not queued.
module jtag_master #(
    parameter int MAX_LEN = 32
) (
    input  logic               TCK,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data
);

    localparam int CW = $clog2(MAX_LEN) + 1;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [CW-1:0] RST_LAST = CW'(6);
    localparam logic [CW-1:0] FULL_LEN = CW'(MAX_LEN);

    typedef enum logic [2:0] {
        RST_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
    } state_t;

    state_t             state, state_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic [CW-1:0]      len_q, len_eff;
    logic               ir_q;
    logic [MAX_LEN-1:0] data_q, cap_q;
    logic               tms_d, tdi_d, ready_d, vld_d, accept, shift_en;

    always_comb begin
        len_eff = CW'(cmd_len);
        if (cmd_len == 6'd0 || cmd_len > 6'(MAX_LEN))
            len_eff = FULL_LEN;
    end

    // State names label the TMS value currently on the wire; outputs are
    // decoded from the next state so they register alongside it.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        accept   = 1'b0;
        shift_en = 1'b0;
        tms_d    = 1'b0;
        tdi_d    = 1'b0;
        ready_d  = 1'b0;
        vld_d    = 1'b0;
        case (state)
            RST_SEQ: begin
                if (cnt == RST_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_op[1]) begin
                        state_d = RST_SEQ;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = SEL_DR;
                    end
                end
            end
            SEL_DR:  state_d = ir_q ? SEL_IR : CAPTURE;
            SEL_IR:  state_d = CAPTURE;
            CAPTURE: begin
                state_d = SHIFT;
                cnt_d   = '0;
            end
            // cnt 0 is the entry cycle; cnt k carries data bit k-1.
            SHIFT: begin
                if (cnt == len_q) begin
                    state_d = EXIT1;
                    cnt_d   = '0;
                end else begin
                    cnt_d    = cnt + 1'b1;
                    shift_en = 1'b1;
                end
            end
            EXIT1:   state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = RST_SEQ;
        endcase

        case (state_d)
            RST_SEQ:              tms_d = (cnt_d != RST_LAST);
            IDLE:                 ready_d = 1'b1;
            SEL_DR, SEL_IR, EXIT1: tms_d = 1'b1;
            SHIFT: begin
                tms_d = (cnt_d == len_q);
                tdi_d = shift_en & data_q[0];
            end
            UPDATE:               vld_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge TCK or posedge rst) begin
        if (rst) begin
            state     <= RST_SEQ;
            cnt       <= '0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            TMS       <= tms_d;
            TDI       <= tdi_d;
            cmd_ready <= ready_d;
            rsp_valid <= vld_d;
        end
    end

    always_ff @(posedge TCK or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            ir_q     <= 1'b0;
            data_q   <= '0;
            cap_q    <= '0;
            rsp_data <= '0;
        end else begin
            if (accept) begin
                len_q  <= len_eff;
                ir_q   <= (cmd_op == 2'd1);
                data_q <= cmd_data;
                cap_q  <= '0;
            end else if (shift_en) begin
                data_q <= data_q >> 1;
            end
            if (state == SHIFT && cnt != '0)
                cap_q[IW'(cnt - 1'b1)] <= TDO;
            if (vld_d)
                rsp_data <= cap_q;
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Directed bench for jtag_master: per-cycle TMS/TDI scoreboard plus a behavioural TAP target supplying TDO.
module tb_jtag_master;

    logic        tck = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [5:0]  cmd_len = 6'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        tms, tdi, tdo;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    int checks = 0;
    int failures = 0;

    bit          exp_tms_q[$];
    bit          exp_tdi_q[$];
    logic [31:0] exp_rsp_q[$];

    always #5 tck = ~tck;

    jtag_master #(.MAX_LEN(32)) dut (
        .TCK(tck), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .TMS(tms), .TDI(tdi), .TDO(tdo),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    // Standard 16-state TAP with a 4-bit IR that captures 4'b0101; DR path loops TDI back.
    localparam logic [3:0] TLR = 4'd0,  RTI = 4'd1,  SDR = 4'd2,  CDR = 4'd3,
                           SHDR = 4'd4, E1DR = 4'd5, PDR = 4'd6,  E2DR = 4'd7,
                           UDR = 4'd8,  SIR = 4'd9,  CIR = 4'd10, SHIR = 4'd11,
                           E1IR = 4'd12, PIR = 4'd13, E2IR = 4'd14, UIR = 4'd15;

    logic [3:0] tap = TLR;
    logic [3:0] ir_sr = 4'd0;
    logic [3:0] ir_reg = 4'hF;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDR  : RTI;
            SDR:  return m ? SIR  : CDR;
            CDR:  return m ? E1DR : SHDR;
            SHDR: return m ? E1DR : SHDR;
            E1DR: return m ? UDR  : PDR;
            PDR:  return m ? E2DR : PDR;
            E2DR: return m ? UDR  : SHDR;
            UDR:  return m ? SDR  : RTI;
            SIR:  return m ? TLR  : CIR;
            CIR:  return m ? E1IR : SHIR;
            SHIR: return m ? E1IR : SHIR;
            E1IR: return m ? UIR  : PIR;
            PIR:  return m ? E2IR : PIR;
            E2IR: return m ? UIR  : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    always @(posedge tck) begin
        if (tap == CIR)
            ir_sr <= 4'b0101;
        else if (tap == SHIR)
            ir_sr <= {tdi, ir_sr[3:1]};
        if (tap == UIR)
            ir_reg <= ir_sr;
        tap <= tap_next(tap, tms);
    end

    assign tdo = (tap == SHIR) ? ir_sr[0] : tdi;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called with rst high; releases it and checks the 5x TMS=1, TMS=0, ready sequence.
    task automatic reset_release_check();
        check_bit("rst_tms", tms, 1'b1);
        check_bit("rst_tdi", tdi, 1'b0);
        check_bit("rst_ready", cmd_ready, 1'b0);
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        check_word("rst_rsp_data", rsp_data, 32'd0);
        @(negedge tck);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge tck);
            if (k < 7) begin
                check_bit("rstseq_tms", tms, (k < 6));
                check_bit("rstseq_tdi", tdi, 1'b0);
                check_bit("rstseq_ready", cmd_ready, 1'b0);
            end else begin
                check_bit("rstseq_ready_7th", cmd_ready, 1'b1);
                check_word("rstseq_rsp_data", rsp_data, 32'd0);
                check_bit("rstseq_tap_rti", (tap == RTI), 1'b1);
            end
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                           input logic [31:0] exp_rsp, input bit toggle, input int abort_at);
        int n, cyc, waits;
        bit is_scan, last;
        logic [31:0] prev_rsp;
        n = (len == 6'd0 || len > 6'd32) ? 32 : int'(len);
        is_scan = (op < 2'd2);
        waits = 0;
        while (cmd_ready !== 1'b1 && waits < 64) begin
            @(negedge tck);
            waits++;
        end
        check_bit("ready_before_cmd", cmd_ready, 1'b1);
        if (is_scan) begin
            exp_tms_q.push_back(1'b1); exp_tdi_q.push_back(1'b0);
            if (op == 2'd1) begin
                exp_tms_q.push_back(1'b1); exp_tdi_q.push_back(1'b0);
            end
            for (int i = 0; i < 2; i++) begin
                exp_tms_q.push_back(1'b0); exp_tdi_q.push_back(1'b0);
            end
            for (int i = 0; i < n; i++) begin
                exp_tms_q.push_back(i == n - 1); exp_tdi_q.push_back(data[i]);
            end
            exp_tms_q.push_back(1'b1); exp_tdi_q.push_back(1'b0);
            exp_tms_q.push_back(1'b0); exp_tdi_q.push_back(1'b0);
            exp_rsp_q.push_back(exp_rsp);
        end else begin
            for (int i = 0; i < 6; i++) begin
                exp_tms_q.push_back(i < 5); exp_tdi_q.push_back(1'b0);
            end
        end
        prev_rsp  = rsp_data;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cyc = 0;
        while (exp_tms_q.size() > 0) begin
            @(negedge tck);
            cyc++;
            if (toggle) begin
                cmd_valid = ~cmd_valid;
                cmd_data  = $urandom;
                cmd_op    = 2'($urandom);
                cmd_len   = 6'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            last = (exp_tms_q.size() == 1);
            check_bit("tms", tms, exp_tms_q.pop_front());
            check_bit("tdi", tdi, exp_tdi_q.pop_front());
            check_bit("busy_ready", cmd_ready, 1'b0);
            check_bit("rsp_valid", rsp_valid, is_scan && last);
            if (rsp_valid === 1'b1 && exp_rsp_q.size() > 0)
                check_word("rsp_data", rsp_data, exp_rsp_q.pop_front());
            if (cyc == abort_at) begin
                rst = 1'b1;
                #1;
                check_bit("abort_tms", tms, 1'b1);
                check_bit("abort_tdi", tdi, 1'b0);
                check_bit("abort_ready", cmd_ready, 1'b0);
                check_bit("abort_rsp_valid", rsp_valid, 1'b0);
                check_word("abort_rsp_data", rsp_data, 32'd0);
                exp_tms_q.delete();
                exp_tdi_q.delete();
                exp_rsp_q.delete();
                cmd_valid = 1'b0;
                return;
            end
        end
        @(negedge tck);
        cmd_valid = 1'b0;
        check_bit("done_ready", cmd_ready, 1'b1);
        check_bit("done_rsp_valid_low", rsp_valid, 1'b0);
        check_bit("done_tap_rti", (tap == RTI), 1'b1);
        if (is_scan)
            check_bit("rsp_consumed", (exp_rsp_q.size() == 0), 1'b1);
        else
            check_word("tapreset_rsp_held", rsp_data, prev_rsp);
    endtask

    initial begin
        repeat (3) @(negedge tck);
        reset_release_check();

        run_cmd(2'd0, 6'd8, 32'h0000_00A5, 32'h0000_00A5, 1'b0, -1);
        run_cmd(2'd1, 6'd4, 32'h0000_0003, 32'h0000_0005, 1'b0, -1);
        check_word("ir_reg_updated", {28'd0, ir_reg}, 32'h0000_0003);
        run_cmd(2'd0, 6'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, -1);
        run_cmd(2'd0, 6'd40, 32'hC3A5_5A3C, 32'hC3A5_5A3C, 1'b0, -1);
        run_cmd(2'd0, 6'd16, 32'h1234_5678, 32'h0000_5678, 1'b1, -1);
        run_cmd(2'd2, 6'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, -1);
        run_cmd(2'd3, 6'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, -1);
        run_cmd(2'd0, 6'd1, 32'h0000_0001, 32'h0000_0001, 1'b0, -1);

        // Abort during shift cycle 3 of a 16-bit scan (cycle 7 after accept).
        run_cmd(2'd0, 6'd16, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 7);
        for (int k = 0; k < 2; k++) begin
            @(negedge tck);
            check_bit("held_rst_tms", tms, 1'b1);
            check_bit("held_rst_rsp_valid", rsp_valid, 1'b0);
        end
        reset_release_check();
        run_cmd(2'd0, 6'd32, 32'h8001_7FFE, 32'h8001_7FFE, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 SHALL have the parameter MAX_LEN, default 32, giving the maximum scan length in bits.
REQ-002 TCK  input  1  single clock; all state changes on posedge TCK.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  master idle, command accepted when cmd_valid && cmd_ready at posedge.
REQ-006 cmd_op  input  2  operation: 0 = DR scan, 1 = IR scan, 2 = TAP reset, 3 = reserved (treated as TAP reset).
REQ-007 cmd_len  input  6  scan length in bits, 1..MAX_LEN.
REQ-008 cmd_data  input  MAX_LEN  bits to shift out on TDI, LSB first.
REQ-009 TMS  output  1  registered test mode select to target TAP.
REQ-010 TDI  output  1  registered serial data to target.
REQ-011 TDO  input  1  serial data from target (e.g. core_logic TDO).
REQ-012 rsp_valid  output  1  one-cycle pulse, scan complete.
REQ-013 rsp_data  output  MAX_LEN  captured TDO bits; holds until the next scan completes.

Function
REQ-014 SHALL register all outputs, which change only on posedge TCK.
REQ-015 SHALL implement the states RST_SEQ, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, and SHALL mirror the target TAP path.
REQ-016 cmd_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: TMS=0, TDI=0; on accept, cmd_data, cmd_len and cmd_op SHALL be latched.
REQ-018 DR scan TMS sequence after the accept cycle: 1 (SEL_DR), 0 (CAPTURE), 0 (enter SHIFT), then N shift cycles, then 1 (UPDATE), 0 (IDLE).
- Shift cycles: TMS=0 for bits 0..N-2, TMS=1 for bit N-1 (to EXIT1).
REQ-019 IR scan SHALL be the same as a DR scan with an extra TMS=1 cycle (SEL_IR) after SEL_DR.
REQ-020 Scan cycle counts from the accept edge to cmd_ready re-asserting: N+6 for DR, N+7 for IR.
REQ-021 During shift cycle i (0..N-1), TDI SHALL equal latched cmd_data[i]; TDI=0 in all non-shift cycles.
REQ-022 TDO SHALL be sampled at the posedge ending shift cycle i and written to shift_reg[i]; bits N..MAX_LEN-1 SHALL be 0.
REQ-023 rsp_data SHALL load the completed shift register, and rsp_valid SHALL pulse for exactly one cycle, on the cycle TMS=0 is driven for UPDATE->IDLE; cmd_ready SHALL assert the following cycle.
REQ-024 cmd_len=0 or cmd_len>MAX_LEN SHALL be clamped to MAX_LEN.
REQ-025 TAP reset op (cmd_op 2 or 3): TMS=1 for 5 cycles, then TMS=0 for 1 cycle, then IDLE.
- No rsp_valid pulse; rsp_data unchanged.
REQ-026 cmd_valid while busy SHALL be ignored; no queuing, and latched command fields SHALL be unaffected by input changes mid-scan.
REQ-027 Shift bit counter width SHALL be ceil(log2(MAX_LEN))+1; no wrap at MAX_LEN=32.

Reset
REQ-028 While rst=1: TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0, state=RST_SEQ, counters=0.
REQ-029 After rst deasserts, SHALL execute the REQ-025 sequence before the first cmd_ready=1 (7th posedge after release).
REQ-030 rst asserted mid-scan SHALL abort immediately: no rsp_valid, rsp_data cleared, RST_SEQ restarted.

Verification
REQ-031 Release rst -> TMS 1,1,1,1,1,0 on successive cycles, cmd_ready=1 on the 7th posedge, rsp_data=0.
REQ-032 DR scan, len=8, data=0xA5, TDO looped from TDI -> TMS 1,0,0,0*7,1,1,0; TDI bits 1,0,1,0,0,1,0,1; rsp_data=0x000000A5; rsp_valid pulse; 14 cycles to cmd_ready.
REQ-033 IR scan, len=4, data=0x3, target core_logic after its reset -> TMS 1,1,0,0,0,0,0,1,1,0; 11 cycles; rsp_data bits match the TDO model.
REQ-034 DR scan, len=0 and len=40 -> both behave as 32-bit scans; 38 cycles each; rsp_data full width.
REQ-035 Assert rst at shift cycle 3 of a 16-bit scan -> TMS=1 immediately, no rsp_valid, rsp_data=0, reset sequence repeats.
REQ-036 Toggle cmd_valid and cmd_data every cycle during a scan -> the scan uses the latched data unchanged, no second command accepted until cmd_ready.
